// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between a valid/ready request port and a byte-addressed dmem.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              dm_e,
    output logic              dm_r,
    output logic              dm_w,
    output logic [1:0]        dm_opt,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic        misaligned;
    logic        reject;
    logic [31:0] ext;
    logic        unused_addr;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign unused_addr = ^req_addr[31:ADDR_W];
    assign reject      = req_size == 2'b11 || misaligned;
    assign req_ready   = state == IDLE && !rst;
    assign resp_valid  = state == RESP;
    assign dm_e        = state == ACCESS;
    assign dm_r        = dm_e && !we_q;
    assign dm_w        = dm_e && we_q;
    assign dm_opt      = size_q == 2'b10 ? 2'b11 : size_q;

    always_comb
        ext = size_q == 2'b00 ? {{24{!uns_q && dm_rdata[7]}}, dm_rdata[7:0]} :
              size_q == 2'b01 ? {{16{!uns_q && dm_rdata[15]}}, dm_rdata[15:0]} : dm_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            resp_rdata <= '0;
            resp_err   <= reject;
            state      <= reject ? RESP : ACCESS;
            if (!reject) begin
                we_q     <= req_we;
                uns_q    <= req_unsigned;
                size_q   <= req_size;
                dm_addr  <= req_addr[ADDR_W-1:0];
                dm_wdata <= req_wdata;
            end
        end else if (state == ACCESS) begin
            if (!we_q)
                resp_rdata <= ext;
            state <= RESP;
        end else if (state == RESP && resp_ready) begin
            state <= IDLE;
        end
    end
endmodule
